// File: rtl/axi_counter_master.sv
// AXI master that writes REG_COUNT consecutive counter values into a register
// slave, reads back the slave's CRC word and compares it with a local XOR.
module axi_counter_master #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter int         REG_COUNT  = 8,
    parameter logic [3:0] AXI_ID     = 4'h0
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   seed_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   crc_o,
    output logic                    mismatch_o,
    output logic                    error_o,
    // write address channel
    output logic [3:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    // write data channel
    output logic [3:0]              wid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    // write response channel
    input  logic [3:0]              bid_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    // read address channel
    output logic [3:0]              arid_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    // read data channel
    input  logic [3:0]              rid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    localparam int                    IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(REG_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] CRC_ADDR = ADDR_WIDTH'(4 * REG_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0] r_crc;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_wlast;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mismatch;
    logic                  r_error;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_ok;
    logic                  w_w_ok;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_last;
    logic [IDX_W-1:0]      w_idx_inc;
    logic                  w_unused;

    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign w_aw_hs   = r_awvalid & awready_i;
    assign w_w_hs    = r_wvalid & wready_i;
    assign w_aw_ok   = ~r_awvalid | awready_i;
    assign w_w_ok    = ~r_wvalid | wready_i;
    assign w_b_hs    = r_bready & bvalid_i;
    assign w_ar_hs   = r_arvalid & arready_i;
    assign w_r_hs    = r_rready & rvalid_i;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_inc = r_idx + IDX_W'(1);

    // IDs and last flags of the read/response channels carry no information here.
    assign w_unused  = ^{bid_i, rid_i, rlast_i};

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_i)            w_next_state = S_WRITE;
            S_WRITE: if (w_aw_ok && w_w_ok)  w_next_state = S_WRESP;
            S_WRESP: if (w_b_hs)             w_next_state = w_last ? S_RADDR : S_WRITE;
            S_RADDR: if (w_ar_hs)            w_next_state = S_RDATA;
            S_RDATA: if (w_r_hs)             w_next_state = S_DONE;
            S_DONE:                          w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
        endcase
    end

    // Every output is a flop; each one is set on entry to the state that owns it.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_idx      <= '0;
            r_acc      <= '0;
            r_wdata    <= '0;
            r_awaddr   <= '0;
            r_araddr   <= '0;
            r_crc      <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_wlast    <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_wdata    <= seed_i;
                        r_awaddr   <= '0;
                        r_error    <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_busy     <= 1'b1;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_wlast    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_acc    <= r_acc ^ r_wdata;
                        if (bresp_i != 2'b00) begin
                            r_error <= 1'b1;
                        end
                        if (w_last) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= CRC_ADDR;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_awaddr  <= ADDR_WIDTH'({w_idx_inc, 2'b00});
                            r_wdata   <= r_wdata + DATA_WIDTH'(1);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_wlast   <= 1'b1;
                        end
                    end
                end
                S_RADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_RDATA: begin
                    if (w_r_hs) begin
                        r_rready   <= 1'b0;
                        r_crc      <= rdata_i;
                        r_mismatch <= (rdata_i != r_acc);
                        r_done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign crc_o      = r_crc;
    assign mismatch_o = r_mismatch;
    assign error_o    = r_error;

    assign awid_o     = AXI_ID;
    assign awaddr_o   = r_awaddr;
    assign awvalid_o  = r_awvalid;

    assign wid_o      = AXI_ID;
    assign wdata_o    = r_wdata;
    assign wstrb_o    = '1;
    assign wlast_o    = r_wlast;
    assign wvalid_o   = r_wvalid;

    assign bready_o   = r_bready;

    assign arid_o     = AXI_ID;
    assign araddr_o   = r_araddr;
    assign arvalid_o  = r_arvalid;

    assign rready_o   = r_rready;

endmodule
